conv_window_gen: RTL and testbench

- Sliding-window producer that feeds the 5x5 binary convolution block.
- Accepts a raster-order stream of signed 32-bit feature-map pixels, one per cycle, for a square map of side Ni (28 for layer 1, 12 for layer 2).
- Uses four circular line buffers to emit, per accepted pixel, one vertical 5-pixel column on the 160-bit taps bus.
- The conv block shifts these columns horizontally to form its 5x5 window.

---
 rtl/conv_window_gen.sv | 166 ++++++++++++++++
 tb/tb_conv_window_gen.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
//
// Sliding-window producer for the 5x5 binary convolution block. Takes a
// raster-order stream of signed 32-bit feature-map pixels for a square map
// of side Ni (N0 or N1, chosen at start) and, for every accepted pixel,
// presents one vertical column of five pixels taken from the same x position
// of rows y-4..y. The conv block shifts these columns sideways to build its
// 5x5 window. Four circular line buffers hold the previous four rows.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      single-cycle pulse that begins a frame (only honoured when idle)
//   state      layer select sampled with start: 0 -> Ni=N0, 1 -> Ni=N1
//   din        signed pixel, raster order
//   din_valid  din carries a pixel this cycle
//   taps       {row y-4, y-3, y-2, y-1, y} at column x, DW bits each
//   tvalid     taps holds a complete column (y >= 4)
//   wvalid     the conv shift registers now hold a full window (y>=4, x>=4)
//   col, row   x / y of the column on taps
//   busy       frame in progress
//   done       one-cycle pulse at frame completion
// ---------------------------------------------------------------------------
module conv_window_gen #(
  parameter int K  = 5,
  parameter int DW = 32,
  parameter int N0 = 28,
  parameter int N1 = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            state,
  input  logic [DW-1:0]   din,
  input  logic            din_valid,
  output logic [K*DW-1:0] taps,
  output logic            tvalid,
  output logic            wvalid,
  output logic [4:0]      col,
  output logic [4:0]      row,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [4:0] NI0 = 5'(N0);
  localparam logic [4:0] NI1 = 5'(N1);

  logic [1:0]    fsm;
  logic [4:0]    ni;
  logic [4:0]    x;
  logic [4:0]    y;
  logic [4:0]    p;

  // Storage is always sized for the larger map; the smaller layer simply
  // uses the low Ni entries.
  logic [DW-1:0] lb0 [N0];
  logic [DW-1:0] lb1 [N0];
  logic [DW-1:0] lb2 [N0];
  logic [DW-1:0] lb3 [N0];

  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic [DW-1:0] rd3;

  logic          accept;
  logic          last_col;
  logic          last_row;
  logic          last_ptr;

  assign accept   = (fsm == S_RUN) && din_valid;
  assign last_col = (x == ni - 5'd1);
  assign last_row = (y == ni - 5'd1);
  assign last_ptr = (p == ni - 5'd1);

  // Asynchronous reads give the values stored one, two, three and four rows
  // ago at this column; the write below lands at the same edge, so each
  // buffer is effectively read-before-write.
  assign rd0 = lb0[p];
  assign rd1 = lb1[p];
  assign rd2 = lb2[p];
  assign rd3 = lb3[p];

  // Line buffers cascade: each row of data moves one buffer deeper every time
  // the pointer passes over it. No reset is needed because rows 0-3 of a
  // frame rewrite every location before anything from them reaches tvalid.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      lb0[p] <= din;
      lb1[p] <= rd0;
      lb2[p] <= rd1;
      lb3[p] <= rd2;
    end
  end

  // Frame control, counters and the registered output column. The valid
  // flags default low so that they only pulse on the cycle after an
  // accepted pixel; taps/col/row hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm    <= S_IDLE;
      ni     <= NI0;
      x      <= 5'd0;
      y      <= 5'd0;
      p      <= 5'd0;
      taps   <= '0;
      tvalid <= 1'b0;
      wvalid <= 1'b0;
      col    <= 5'd0;
      row    <= 5'd0;
    end else begin
      tvalid <= 1'b0;
      wvalid <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (start) begin
            ni  <= state ? NI1 : NI0;
            x   <= 5'd0;
            y   <= 5'd0;
            p   <= 5'd0;
            fsm <= S_RUN;
          end
        end
        S_RUN: begin
          if (din_valid) begin
            taps   <= {rd3, rd2, rd1, rd0, din};
            col    <= x;
            row    <= y;
            tvalid <= (y >= 5'd4);
            wvalid <= (y >= 5'd4) && (x >= 5'd4);
            p      <= last_ptr ? 5'd0 : p + 5'd1;
            if (last_col) begin
              x <= 5'd0;
              // y is left at Ni-1 on the final pixel; it is cleared by the
              // next start.
              if (last_row) begin
                fsm <= S_FIN;
              end else begin
                y <= y + 5'd1;
              end
            end else begin
              x <= x + 5'd1;
            end
          end
        end
        S_FIN: begin
          fsm <= S_IDLE;
        end
        default: begin
          fsm <= S_IDLE;
        end
      endcase
    end
  end

  // FIN is entered on the same edge that loads the final column, so decoding
  // the state lines up done with that column's tvalid.
  assign busy = (fsm == S_RUN);
  assign done = (fsm == S_FIN);

endmodule

// File: tb/tb_conv_window_gen.sv
// ---------------------------------------------------------------------------
// tb_conv_window_gen
//
// Directed self-checking bench for conv_window_gen. A behavioural reference
// (pixel formula plus frame bookkeeping) predicts every output each cycle;
// hand-computed columns are checked at the first/last columns of frames.
// ---------------------------------------------------------------------------
module tb_conv_window_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         state;
  logic [31:0]  din;
  logic         din_valid;
  logic [159:0] taps;
  logic         tvalid;
  logic         wvalid;
  logic [4:0]   col;
  logic [4:0]   row;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  conv_window_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .state     (state),
    .din       (din),
    .din_valid (din_valid),
    .taps      (taps),
    .tvalid    (tvalid),
    .wvalid    (wvalid),
    .col       (col),
    .row       (row),
    .busy      (busy),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: phase 0=idle, 1=run, 2=fin.
  int           phase = 0;
  int           mNi = 28;
  int           mX = 0;
  int           mY = 0;
  logic [159:0] mTaps = '0;
  bit           mTapsKnown = 1'b0;
  logic [4:0]   mCol = 5'd0;
  logic [4:0]   mRow = 5'd0;
  bit           mTv = 1'b0;
  bit           mWv = 1'b0;
  bit           negMode = 1'b0;

  // Per-frame observations of the DUT.
  int           tvCount;
  int           wvCount;
  int           doneCount;
  int           acceptCount;
  logic [159:0] firstTvTaps;
  logic [4:0]   firstTvRow;
  logic [4:0]   firstTvCol;
  logic [159:0] firstWvTaps;
  logic [4:0]   firstWvRow;
  logic [4:0]   firstWvCol;
  logic [159:0] doneTaps;
  logic         doneTv;
  logic         doneBusy;
  logic [4:0]   doneRow;
  logic [4:0]   doneCol;

  task automatic checkOutput(input string tag, input logic [159:0] actual,
                             input logic [159:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] pix(input int y, input int x);
    int v;
    v = 100 * y + x;
    return negMode ? 32'(-v - 1) : 32'(v);
  endfunction

  task automatic clearStats();
    tvCount     = 0;
    wvCount     = 0;
    doneCount   = 0;
    acceptCount = 0;
    firstTvTaps = '0;
    firstTvRow  = '0;
    firstTvCol  = '0;
    firstWvTaps = '0;
    firstWvRow  = '0;
    firstWvCol  = '0;
    doneTaps    = '0;
    doneTv      = 1'b0;
    doneBusy    = 1'b1;
    doneRow     = '0;
    doneCol     = '0;
  endtask

  task automatic updateModel(input bit r, input bit s, input bit st, input bit v);
    if (r) begin
      phase      = 0;
      mX         = 0;
      mY         = 0;
      mTaps      = '0;
      mTapsKnown = 1'b1;
      mCol       = 5'd0;
      mRow       = 5'd0;
      mTv        = 1'b0;
      mWv        = 1'b0;
    end else begin
      mTv = 1'b0;
      mWv = 1'b0;
      case (phase)
        0: if (s) begin
          mNi   = st ? 12 : 28;
          mX    = 0;
          mY    = 0;
          phase = 1;
        end
        1: if (v) begin
          acceptCount++;
          mCol = 5'(mX);
          mRow = 5'(mY);
          if (mY >= 4) begin
            mTaps = {pix(mY-4, mX), pix(mY-3, mX), pix(mY-2, mX),
                     pix(mY-1, mX), pix(mY, mX)};
            mTapsKnown = 1'b1;
            mTv = 1'b1;
            mWv = (mX >= 4);
          end else begin
            mTapsKnown = 1'b0;
          end
          if (mX == mNi - 1) begin
            mX = 0;
            if (mY == mNi - 1) phase = 2;
            else mY++;
          end else begin
            mX++;
          end
        end
        default: phase = 0;
      endcase
    end
  endtask

  task automatic compareAll();
    checkOutput("tvalid", 160'(tvalid), 160'(mTv));
    checkOutput("wvalid", 160'(wvalid), 160'(mWv));
    checkOutput("busy",   160'(busy),   160'(phase == 1));
    checkOutput("done",   160'(done),   160'(phase == 2));
    checkOutput("col",    160'(col),    160'(mCol));
    checkOutput("row",    160'(row),    160'(mRow));
    if (mTapsKnown) checkOutput("taps", taps, mTaps);
    if (tvalid) begin
      tvCount++;
      if (tvCount == 1) begin
        firstTvTaps = taps;
        firstTvRow  = row;
        firstTvCol  = col;
      end
    end
    if (wvalid) begin
      wvCount++;
      if (wvCount == 1) begin
        firstWvTaps = taps;
        firstWvRow  = row;
        firstWvCol  = col;
      end
    end
    if (done) begin
      doneCount++;
      doneTaps = taps;
      doneTv   = tvalid;
      doneBusy = busy;
      doneRow  = row;
      doneCol  = col;
    end
  endtask

  // One clock of stimulus: drive at the falling edge, let the DUT and the
  // model take the rising edge, then compare at the next falling edge.
  task automatic applyStimulus(input bit r, input bit s, input bit st, input bit v);
    rst       = r;
    start     = s;
    state     = st;
    din_valid = v;
    din       = (phase == 1) ? pix(mY, mX) : 32'hDEAD_BEEF;
    @(posedge clk);
    updateModel(r, s, st, v);
    @(negedge clk);
    compareAll();
  endtask

  // Runs one frame. gapMode inserts idle cycles between pixels, midNoise
  // pulses start/toggles state while running, abortRow>=0 resets the DUT
  // on reaching that row.
  task automatic runFrame(input bit sel, input bit gapMode, input bit midNoise,
                          input int abortRow);
    int  guard;
    bit  toggle;
    bit  s;
    bit  st;
    guard  = 0;
    toggle = 1'b0;
    clearStats();
    applyStimulus(1'b0, 1'b1, sel, 1'b1);
    while (phase != 0 && guard < 5000) begin
      guard++;
      if (abortRow >= 0 && phase == 1 && mY == abortRow) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        break;
      end
      if (gapMode && phase == 1 && toggle) begin
        repeat (($urandom_range(0, 5) == 0) ? 3 : 1)
          applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
      toggle = !toggle;
      s  = midNoise && (guard % 50 == 7);
      st = midNoise && (guard % 2 == 1);
      applyStimulus(1'b0, s, st, 1'b1);
    end
    if (guard >= 5000) checkOutput("frame_timeout", 160'(phase), 160'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    state     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    @(negedge clk);

    // Reset state, with start asserted to show reset wins.
    $display("[TB] reset");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_taps", taps, 160'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Ni=28, continuous stream.
    $display("[TB] scenario 1: Ni=28 continuous");
    negMode = 1'b0;
    runFrame(1'b0, 1'b0, 1'b0, -1);
    checkOutput("s1_tv_count",   160'(tvCount),   160'(672));
    checkOutput("s1_wv_count",   160'(wvCount),   160'(576));
    checkOutput("s1_done_count", 160'(doneCount), 160'(1));
    checkOutput("s1_first_row",  160'(firstTvRow), 160'(4));
    checkOutput("s1_first_col",  160'(firstTvCol), 160'(0));
    checkOutput("s1_first_taps", firstTvTaps,
                {32'd0, 32'd100, 32'd200, 32'd300, 32'd400});
    checkOutput("s1_done_taps", doneTaps,
                {32'd2327, 32'd2427, 32'd2527, 32'd2627, 32'd2727});
    checkOutput("s1_done_tv",  160'(doneTv),  160'(1));
    checkOutput("s1_done_row", 160'(doneRow), 160'(27));
    checkOutput("s1_done_col", 160'(doneCol), 160'(27));

    // Ni=12, continuous stream.
    $display("[TB] scenario 2: Ni=12 continuous");
    runFrame(1'b1, 1'b0, 1'b0, -1);
    checkOutput("s2_tv_count",   160'(tvCount),   160'(96));
    checkOutput("s2_wv_count",   160'(wvCount),   160'(64));
    checkOutput("s2_done_count", 160'(doneCount), 160'(1));
    checkOutput("s2_wv_row",     160'(firstWvRow), 160'(4));
    checkOutput("s2_wv_col",     160'(firstWvCol), 160'(4));
    checkOutput("s2_wv_taps", firstWvTaps,
                {32'd4, 32'd104, 32'd204, 32'd304, 32'd404});
    checkOutput("s2_done_busy",  160'(doneBusy),  160'(0));

    // Ni=12 with gaps in din_valid.
    $display("[TB] scenario 3: Ni=12 with gaps");
    runFrame(1'b1, 1'b1, 1'b0, -1);
    checkOutput("s3_tv_count",   160'(tvCount),   160'(96));
    checkOutput("s3_wv_count",   160'(wvCount),   160'(64));
    checkOutput("s3_done_count", 160'(doneCount), 160'(1));

    // Negative pixels.
    $display("[TB] scenario 4: negative pixels");
    negMode = 1'b1;
    runFrame(1'b1, 1'b0, 1'b0, -1);
    checkOutput("s4_first_taps", firstTvTaps,
                {32'hFFFF_FFFF, 32'hFFFF_FF9B, 32'hFFFF_FF37,
                 32'hFFFF_FED3, 32'hFFFF_FE6F});
    checkOutput("s4_tv_count", 160'(tvCount), 160'(96));
    negMode = 1'b0;

    // start/state noise during an Ni=28 frame.
    $display("[TB] scenario 5: start/state noise mid-frame");
    runFrame(1'b0, 1'b0, 1'b1, -1);
    checkOutput("s5_accepted",   160'(acceptCount), 160'(784));
    checkOutput("s5_tv_count",   160'(tvCount),   160'(672));
    checkOutput("s5_wv_count",   160'(wvCount),   160'(576));
    checkOutput("s5_done_count", 160'(doneCount), 160'(1));

    // Abort an Ni=28 frame at row 10, then run Ni=12.
    $display("[TB] scenario 6: abort then Ni=12");
    runFrame(1'b0, 1'b0, 1'b0, 10);
    checkOutput("s6_abort_no_done", 160'(doneCount), 160'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("s6_abort_taps",   taps,          160'd0);
    checkOutput("s6_abort_tvalid", 160'(tvalid),  160'(0));
    checkOutput("s6_abort_busy",   160'(busy),    160'(0));
    checkOutput("s6_abort_row",    160'(row),     160'(0));
    runFrame(1'b1, 1'b0, 1'b0, -1);
    checkOutput("s6_tv_count",   160'(tvCount),   160'(96));
    checkOutput("s6_done_count", 160'(doneCount), 160'(1));
    checkOutput("s6_first_taps", firstTvTaps,
                {32'd0, 32'd100, 32'd200, 32'd300, 32'd400});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
